// File: rtl/elm_pkg.sv
// Shared ELM definitions: image geometry, word type and serializer state encoding.
// Used by the image serializer, the ELM core and the image/answer ROMs.
package elm_pkg;

    localparam int IMG_W   = 256;
    localparam int WORD_W  = 16;
    localparam int N_WORDS = 16;
    localparam int CNT_W   = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IMG_W-1:0]  image_t;
    typedef logic [CNT_W-1:0]  count_t;

    // Idle marker for serial_count and index of the final word of an image
    localparam count_t CNT_IDLE = count_t'(N_WORDS);
    localparam count_t CNT_LAST = count_t'(N_WORDS - 1);

    typedef enum logic {
        ST_IDLE_LOAD = 1'b0,
        ST_SEND      = 1'b1
    } ser_state_e;

    // Select word idx (row idx, LSB row is word 0) out of a full image.
    // Out-of-range indices return zero rather than aliasing onto a real row.
    function automatic word_t word_at(input image_t image, input count_t idx);
        word_t w;
        w = {WORD_W{1'b0}};
        for (int k = 0; k < N_WORDS; k++) begin
            if (idx == count_t'(k)) begin
                w = image[k*WORD_W +: WORD_W];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/image_serializer.sv
// Captures a 256-bit binary image while set is high and, once set falls,
// streams it to the ELM core as 16 row words, one per clock, word 0 first.
// A new set at any time aborts the current stream and restarts with the new image.
module image_serializer
    import elm_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [IMG_W-1:0]  img,
    input  logic              set,
    output logic [WORD_W-1:0] serial_img,
    output logic [CNT_W-1:0]  serial_count,
    output logic              ser_tx
);

    ser_state_e state_q, state_d;
    image_t     img_reg_q, img_reg_d;
    count_t     ptr_q, ptr_d;
    word_t      serial_img_q, serial_img_d;
    count_t     serial_count_q, serial_count_d;
    logic       ser_tx_q, ser_tx_d;

    // Next-state and next-output logic: set always wins, otherwise the FSM advances
    always_comb begin
        state_d        = state_q;
        img_reg_d      = img_reg_q;
        ptr_d          = ptr_q;
        serial_img_d   = serial_img_q;
        serial_count_d = serial_count_q;
        ser_tx_d       = ser_tx_q;

        if (set) begin
            // Load (or reload): capture the image and hold the outputs quiet
            img_reg_d      = img;
            ptr_d          = {CNT_W{1'b0}};
            state_d        = ST_SEND;
            serial_img_d   = {WORD_W{1'b0}};
            serial_count_d = {CNT_W{1'b0}};
            ser_tx_d       = 1'b0;
        end else begin
            case (state_q)
                ST_SEND: begin
                    serial_img_d   = word_at(img_reg_q, ptr_q);
                    serial_count_d = ptr_q;
                    ser_tx_d       = 1'b1;
                    if (ptr_q == CNT_LAST) begin
                        state_d = ST_IDLE_LOAD;
                        ptr_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_SEND;
                        ptr_d   = ptr_q + 5'd1;
                    end
                end
                ST_IDLE_LOAD: begin
                    // Done / idle: count parks at N_WORDS and never wraps
                    serial_img_d   = {WORD_W{1'b0}};
                    serial_count_d = CNT_IDLE;
                    ser_tx_d       = 1'b0;
                end
                default: begin
                    state_d        = ST_IDLE_LOAD;
                    ptr_d          = {CNT_W{1'b0}};
                    serial_img_d   = {WORD_W{1'b0}};
                    serial_count_d = CNT_IDLE;
                    ser_tx_d       = 1'b0;
                end
            endcase
        end
    end

    // State, image, pointer and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE_LOAD;
            img_reg_q      <= {IMG_W{1'b0}};
            ptr_q          <= {CNT_W{1'b0}};
            serial_img_q   <= {WORD_W{1'b0}};
            serial_count_q <= CNT_IDLE;
            ser_tx_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            img_reg_q      <= img_reg_d;
            ptr_q          <= ptr_d;
            serial_img_q   <= serial_img_d;
            serial_count_q <= serial_count_d;
            ser_tx_q       <= ser_tx_d;
        end
    end

    assign serial_img   = serial_img_q;
    assign serial_count = serial_count_q;
    assign ser_tx       = ser_tx_q;

endmodule

// File: tb/tb_image_serializer.sv
// Scoreboard bench for image_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares every word presented with ser_tx=1.
module tb_image_serializer;

    logic         clock;
    logic         reset_n;
    logic [255:0] img;
    logic         set;
    logic [15:0]  serial_img;
    logic [4:0]   serial_count;
    logic         ser_tx;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    image_serializer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .img          (img),
        .set          (set),
        .serial_img   (serial_img),
        .serial_count (serial_count),
        .ser_tx       (ser_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] make_img(input logic [15:0] base);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = base + 16'(k);
        return r;
    endfunction

    task automatic push_words(input logic [15:0] base, input int first, input int last);
        exp_t e;
        for (int k = first; k <= last; k++) begin
            e.w = base + 16'(k);
            e.c = 5'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_tx"},  32'(ser_tx),       32'd0);
        check({name, "_cnt"}, 32'(serial_count), 32'd16);
        check({name, "_img"}, 32'(serial_img),   32'd0);
    endtask

    // Monitor: every valid word must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && ser_tx) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {11'd0, serial_count, serial_img}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word",  32'(serial_img),   32'(e.w));
                    check("stream_count", 32'(serial_count), 32'(e.c));
                end
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        set     = 1'b0;
        img     = 256'd0;

        // Reset state, then release with set low
        #12;
        check_idle("reset");
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check_idle("post_reset");

        // Basic stream, set high two cycles; img disturbed one cycle after set falls
        img = make_img(16'hA500);
        set = 1'b1;
        tick(1);
        check("load_tx", 32'(ser_tx), 32'd0);
        check("load_cnt", 32'(serial_count), 32'd0);
        tick(1);
        set = 1'b0;
        push_words(16'hA500, 0, 15);
        tick(1);
        img = {256{1'b1}};
        tick(16);
        check_idle("basic_done");
        tick(2);
        check_idle("basic_idle");

        // Restart at count 7 with a new image
        img = make_img(16'hA500);
        set = 1'b1;
        tick(1);
        set = 1'b0;
        push_words(16'hA500, 0, 7);
        tick(8);
        check("pre_restart_cnt", 32'(serial_count), 32'd7);
        img = make_img(16'h3C00);
        set = 1'b1;
        tick(1);
        check("restart_tx", 32'(ser_tx), 32'd0);
        check("restart_cnt", 32'(serial_count), 32'd0);
        check("restart_img", 32'(serial_img), 32'd0);
        set = 1'b0;
        push_words(16'h3C00, 0, 15);
        tick(17);
        check_idle("restart_done");

        // Async reset mid-stream at count 5
        img = make_img(16'h5A00);
        set = 1'b1;
        tick(1);
        set = 1'b0;
        push_words(16'h5A00, 0, 5);
        tick(6);
        #5;
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        tick(2);
        #3;
        reset_n = 1'b1;
        tick(20);
        check_idle("after_async_reset");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
